alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 56 +++++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of request, shared-ALU and response signals for alu_arbiter.
// "slave" is the arbiter's view; "master" is the surrounding environment
// (the two requesters, the ALU and the response consumer).
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [3:0]   req0_sel;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [3:0]   req1_sel;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         alu_carry;
    logic         alu_overflow;
    logic         alu_sign;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_zero, alu_carry, alu_overflow, alu_sign,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_zero, alu_carry, alu_overflow, alu_sign,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE (grant) -> EXEC (drive ALU,
// capture) -> RESP (hold response until consumed).
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state;
    logic         last_grant;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [3:0]   op_sel;
    logic         op_id;

    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [N-1:0] rsp_result_q;
    logic [3:0]   rsp_flags_q;
    logic         rsp_err_q;

    logic         grant0;
    logic         grant1;
    logic         sel_ok;

    // Grant only while idle; on contention favour whoever did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    // Selects 10..15 have no ALU operation behind them.
    assign sel_ok = (op_sel <= 4'd9);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // ALU inputs are quiet outside EXEC so the shared ALU sees zeros.
    assign bus.alu_a   = (state == EXEC) ? op_a   : '0;
    assign bus.alu_b   = (state == EXEC) ? op_b   : '0;
    assign bus.alu_sel = (state == EXEC) ? op_sel : 4'b0000;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;

    // Control FSM plus operation and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;   // requester 0 wins the first contention
            op_a         <= '0;
            op_b         <= '0;
            op_sel       <= 4'b0000;
            op_id        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_a       <= grant1 ? bus.req1_a   : bus.req0_a;
                        op_b       <= grant1 ? bus.req1_b   : bus.req0_b;
                        op_sel     <= grant1 ? bus.req1_sel : bus.req0_sel;
                        op_id      <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_id_q    <= op_id;
                    rsp_valid_q <= 1'b1;
                    if (sel_ok) begin
                        rsp_result_q <= bus.alu_result;
                        rsp_flags_q  <= {bus.alu_zero, bus.alu_carry,
                                         bus.alu_overflow, bus.alu_sign};
                        rsp_err_q    <= 1'b0;
                    end else begin
                        rsp_result_q <= '0;
                        rsp_flags_q  <= 4'b0000;
                        rsp_err_q    <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the bus.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_arbiter_if #(.N(32)) bus ();

    alu_arbiter #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 AND, 1 OR, 2 ADD, 6 SUB, other legal -> XOR.
    // Unsupported selects produce garbage so the arbiter's masking is visible.
    logic [32:0] sum;
    logic [31:0] res;
    logic        c_f, v_f;
    always_comb begin
        sum = '0;
        res = '0;
        c_f = 1'b0;
        v_f = 1'b0;
        case (bus.alu_sel)
            4'd0: res = bus.alu_a & bus.alu_b;
            4'd1: res = bus.alu_a | bus.alu_b;
            4'd2: begin
                sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                res = sum[31:0];
                c_f = sum[32];
                v_f = (bus.alu_a[31] == bus.alu_b[31]) && (res[31] != bus.alu_a[31]);
            end
            4'd6: begin
                res = bus.alu_a - bus.alu_b;
                v_f = (bus.alu_a[31] != bus.alu_b[31]) && (res[31] != bus.alu_a[31]);
            end
            default: res = bus.alu_a ^ bus.alu_b;
        endcase
        bus.alu_result   = res;
        bus.alu_zero     = (res == 32'd0);
        bus.alu_carry    = c_f;
        bus.alu_overflow = v_f;
        bus.alu_sign     = res[31];
        if (bus.alu_sel >= 4'd10) begin
            bus.alu_result   = 32'hDEADBEEF;
            bus.alu_zero     = 1'b1;
            bus.alu_carry    = 1'b1;
            bus.alu_overflow = 1'b1;
            bus.alu_sign     = 1'b1;
        end
    end

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = s;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = s;
    endtask

    task automatic test_reset;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        bus.rsp_ready = 1'b0;
        #1;
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0h want 0", bus.rsp_valid); end
        n_chk++; if (bus.rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_result: got %0h want 0", bus.rsp_result); end
        n_chk++; if ({bus.rsp_id, bus.rsp_flags, bus.rsp_err} !== 6'd0) begin n_fail++; $display("FAIL reset_rsp_misc: got %0h want 0", {bus.rsp_id, bus.rsp_flags, bus.rsp_err}); end
        n_chk++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== 68'd0) begin n_fail++; $display("FAIL reset_alu_out: got %0h want 0", {bus.alu_a, bus.alu_b, bus.alu_sel}); end
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    // Both requesters valid the whole time: grants must go 0,1,0,1 at II=3.
    task automatic test_contention;
        logic exp_id;
        @(negedge clk);
        drive0(1'b1, 32'd3, 32'd3, 4'b0110);
        drive1(1'b1, 32'hF0, 32'h0F, 4'b0000);
        bus.rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            n_chk++; if ({bus.req0_ready, bus.req1_ready} !== {~exp_id, exp_id}) begin n_fail++; $display("FAIL cont_grant%0d: got %b want %b", i, {bus.req0_ready, bus.req1_ready}, {~exp_id, exp_id}); end
            @(posedge clk); @(negedge clk); #1;
            n_chk++; if (bus.alu_a !== (exp_id ? 32'hF0 : 32'd3)) begin n_fail++; $display("FAIL cont_alu_a%0d: got %0h want %0h", i, bus.alu_a, exp_id ? 32'hF0 : 32'd3); end
            n_chk++; if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin n_fail++; $display("FAIL cont_exec%0d: got %b want 000", i, {bus.rsp_valid, bus.req0_ready, bus.req1_ready}); end
            @(posedge clk); @(negedge clk); #1;
            n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== {1'b1, exp_id, 1'b0}) begin n_fail++; $display("FAIL cont_rsp%0d: got %b want %b", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_err}, {1'b1, exp_id, 1'b0}); end
            n_chk++; if ({bus.rsp_result, bus.rsp_flags} !== {32'd0, 4'b1000}) begin n_fail++; $display("FAIL cont_res%0d: got %0h/%b want 0/1000", i, bus.rsp_result, bus.rsp_flags); end
            @(posedge clk); @(negedge clk); #1;
        end
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic test_single_add;
        drive0(1'b1, 32'd5, 32'd7, 4'b0010);
        bus.rsp_ready = 1'b1;
        #1;
        n_chk++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %0h want 1", bus.req0_ready); end
        @(posedge clk); @(negedge clk);
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        n_chk++; if ({bus.rsp_valid, bus.alu_sel} !== {1'b0, 4'b0010}) begin n_fail++; $display("FAIL add_exec: got %b want 00010", {bus.rsp_valid, bus.alu_sel}); end
        @(posedge clk); @(negedge clk); #1;
        n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== 3'b100) begin n_fail++; $display("FAIL add_rsp: got %b want 100", {bus.rsp_valid, bus.rsp_id, bus.rsp_err}); end
        n_chk++; if ({bus.rsp_result, bus.rsp_flags} !== {32'd12, 4'b0000}) begin n_fail++; $display("FAIL add_res: got %0d/%b want 12/0000", bus.rsp_result, bus.rsp_flags); end
        @(posedge clk); @(negedge clk); #1;
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_done: got %0h want 0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure;
        drive1(1'b1, 32'h7FFFFFFF, 32'd1, 4'b0010);
        bus.rsp_ready = 1'b0;
        #1;
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_grant: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        @(posedge clk); @(negedge clk);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        drive0(1'b1, 32'd9, 32'd4, 4'b0010);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.req0_ready, bus.req1_ready} !== 4'b1100) begin n_fail++; $display("FAIL bp_hold%0d: got %b want 1100", k, {bus.rsp_valid, bus.rsp_id, bus.req0_ready, bus.req1_ready}); end
            n_chk++; if ({bus.rsp_result, bus.rsp_flags, bus.rsp_err} !== {32'h80000000, 4'b0011, 1'b0}) begin n_fail++; $display("FAIL bp_res%0d: got %0h/%b/%0h want 80000000/0011/0", k, bus.rsp_result, bus.rsp_flags, bus.rsp_err); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        n_chk++; if ({bus.rsp_valid, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b want 01", {bus.rsp_valid, bus.req0_ready}); end
        // Requester 0 withdraws before the edge; nothing must be accepted.
        drive0(1'b0, 32'd9, 32'd4, 4'b0010);
        @(posedge clk); @(negedge clk); #1;
        n_chk++; if ({bus.alu_a, bus.rsp_valid} !== 33'd0) begin n_fail++; $display("FAIL bp_withdraw: got %0h want 0", {bus.alu_a, bus.rsp_valid}); end
    endtask

    task automatic test_illegal_sel;
        drive0(1'b1, 32'h55, 32'h0F, 4'b1100);
        bus.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        drive0(1'b0, 32'd1, 32'd2, 4'b0001);
        #1;
        n_chk++; if ({bus.alu_a, bus.alu_sel} !== {32'h55, 4'b1100}) begin n_fail++; $display("FAIL ill_inflight: got %0h want 551100", {bus.alu_a, bus.alu_sel}); end
        @(posedge clk); @(negedge clk);
        bus.req0_valid = 1'b1;
        #1;
        n_chk++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.req0_ready} !== 4'b1100) begin n_fail++; $display("FAIL ill_rsp: got %b want 1100", {bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.req0_ready}); end
        n_chk++; if ({bus.rsp_result, bus.rsp_flags} !== 36'd0) begin n_fail++; $display("FAIL ill_res: got %0h/%b want 0/0000", bus.rsp_result, bus.rsp_flags); end
        @(posedge clk); @(negedge clk); #1;
        n_chk++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL ill_next_grant: got %0h want 1", bus.req0_ready); end
        @(posedge clk); @(negedge clk);
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        @(posedge clk); @(negedge clk); #1;
        n_chk++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_result, bus.rsp_flags} !== {1'b1, 1'b0, 32'd3, 4'b0000}) begin n_fail++; $display("FAIL ill_follow: got %b/%0h/%0d/%b want 1/0/3/0000", bus.rsp_valid, bus.rsp_err, bus.rsp_result, bus.rsp_flags); end
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic test_async_reset;
        drive0(1'b1, 32'hAA, 32'd1, 4'b0010);
        bus.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({bus.rsp_valid, bus.alu_a, bus.alu_sel} !== 37'd0) begin n_fail++; $display("FAIL arst_idle: got %0h want 0", {bus.rsp_valid, bus.alu_a, bus.alu_sel}); end
        n_chk++; if (bus.rsp_result !== 32'd0) begin n_fail++; $display("FAIL arst_result: got %0h want 0", bus.rsp_result); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_rsp%0d: got %0h want 0", k, bus.rsp_valid); end
        end
        drive0(1'b1, 32'd1, 32'd1, 4'b0010);
        drive1(1'b1, 32'd8, 32'd8, 4'b0001);
        #1;
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL arst_first_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        @(posedge clk); @(negedge clk);
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        @(posedge clk); @(negedge clk); #1;
        n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 1'b0, 32'd2}) begin n_fail++; $display("FAIL arst_after: got %b/%0h/%0d want 1/0/2", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_contention;
        test_single_add;
        test_backpressure;
        test_illegal_sel;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
